// File: rtl/tcm_ctrl.sv
// Tightly-coupled memory controller: one 16K x 32 RAM shared by dcache line
// transfers (4-beat fill/write-back) and single-word DMA accesses.
module tcm_ctrl #(
  parameter int WAIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tcm_read_request,
  input  logic         tcm_write_request,
  input  logic [15:0]  tcm_addr,
  input  logic [127:0] tcm_write_data,
  output logic [127:0] tcm_read_data,
  output logic         tcm_request_finish,
  output logic         tcm_invalid,
  output logic [15:0]  tcm_invalid_addr,
  input  logic         dma_req,
  input  logic         dma_we,
  input  logic [3:0]   dma_be,
  input  logic [15:0]  dma_addr,
  input  logic [31:0]  dma_wdata,
  output logic [31:0]  dma_rdata,
  output logic         dma_ack
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LINE_RD = 3'd1,
    LINE_WR = 3'd2,
    DMA_RD  = 3'd3,
    DMA_WR  = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT);

  state_t       state_r;
  state_t       state_s;
  logic [7:0]   wait_cnt_r;
  logic [1:0]   beat_r;
  logic         prio_dma_r;
  logic [127:0] tcm_read_data_r;
  logic         tcm_request_finish_r;
  logic         tcm_invalid_r;
  logic [15:0]  tcm_invalid_addr_r;
  logic [31:0]  dma_rdata_r;
  logic         dma_ack_r;

  logic         beat_last_s;
  logic         cache_req_s;
  logic         grant_dma_s;
  logic         busy_s;
  logic [13:0]  ram_idx_s;
  logic         ram_we_s;
  logic [3:0]   ram_be_s;
  logic [31:0]  ram_wdata_s;
  logic         unused_s;

  logic [31:0]  mem_r [0:16383];

  assign beat_last_s = (wait_cnt_r == WAIT_LAST);
  assign cache_req_s = tcm_read_request | tcm_write_request;
  // prio_dma_r records who lost the last contested arbitration
  assign grant_dma_s = dma_req & (~cache_req_s | prio_dma_r);
  assign busy_s      = (state_r == LINE_RD) || (state_r == LINE_WR) ||
                       (state_r == DMA_RD)  || (state_r == DMA_WR);
  assign unused_s    = ^{tcm_addr[3:0], dma_addr[1:0]};

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_dma_s) begin
          state_s = dma_we ? DMA_WR : DMA_RD;
        end else if (tcm_write_request) begin
          state_s = LINE_WR;
        end else if (tcm_read_request) begin
          state_s = LINE_RD;
        end else begin
          state_s = IDLE;
        end
      end
      LINE_RD, LINE_WR: begin
        if (beat_last_s && (beat_r == 2'd3)) begin
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
      DMA_RD, DMA_WR: begin
        if (beat_last_s) begin
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // RAM address and write-port control; writes land on the last cycle of a beat
  always_comb begin
    ram_idx_s   = {tcm_addr[15:4], beat_r};
    ram_we_s    = 1'b0;
    ram_be_s    = 4'h0;
    ram_wdata_s = 32'h0000_0000;
    if ((state_r == DMA_RD) || (state_r == DMA_WR)) begin
      ram_idx_s = dma_addr[15:2];
    end else begin
      ram_idx_s = {tcm_addr[15:4], beat_r};
    end
    if ((state_r == LINE_WR) && beat_last_s) begin
      ram_we_s    = 1'b1;
      ram_be_s    = 4'hF;
      ram_wdata_s = tcm_write_data[{beat_r, 5'b00000} +: 32];
    end else if ((state_r == DMA_WR) && beat_last_s) begin
      ram_we_s    = 1'b1;
      ram_be_s    = dma_be;
      ram_wdata_s = dma_wdata;
    end else begin
      ram_we_s    = 1'b0;
    end
  end

  // RAM storage: no reset, every byte lane commits in the same edge
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be_s[b]) begin
          mem_r[ram_idx_s][8*b +: 8] <= ram_wdata_s[8*b +: 8];
        end
      end
    end
  end

  // FSM state, beat/wait counters, arbitration flag and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r              <= IDLE;
      wait_cnt_r           <= 8'd0;
      beat_r               <= 2'd0;
      prio_dma_r           <= 1'b0;
      tcm_read_data_r      <= 128'd0;
      tcm_request_finish_r <= 1'b0;
      tcm_invalid_r        <= 1'b0;
      tcm_invalid_addr_r   <= 16'h0000;
      dma_rdata_r          <= 32'h0000_0000;
      dma_ack_r            <= 1'b0;
    end else begin
      state_r <= state_s;
      if (busy_s && beat_last_s) begin
        wait_cnt_r <= 8'd0;
        beat_r     <= beat_r + 2'd1;
      end else if (busy_s) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= 8'd0;
        beat_r     <= 2'd0;
      end
      if ((state_r == IDLE) && dma_req && cache_req_s) begin
        prio_dma_r <= ~grant_dma_s;
      end
      tcm_request_finish_r <= ((state_r == LINE_RD) || (state_r == LINE_WR)) &&
                              (state_s == DONE);
      dma_ack_r     <= ((state_r == DMA_RD) || (state_r == DMA_WR)) && (state_s == DONE);
      tcm_invalid_r <= (state_r == DMA_WR) && (state_s == DONE);
      if ((state_r == DMA_WR) && (state_s == DONE)) begin
        tcm_invalid_addr_r <= {dma_addr[15:4], 4'h0};
      end
      if ((state_r == LINE_RD) && beat_last_s) begin
        tcm_read_data_r[{beat_r, 5'b00000} +: 32] <= mem_r[ram_idx_s];
      end
      if ((state_r == DMA_RD) && beat_last_s) begin
        dma_rdata_r <= mem_r[ram_idx_s];
      end
    end
  end

  assign tcm_read_data      = tcm_read_data_r;
  assign tcm_request_finish = tcm_request_finish_r;
  assign tcm_invalid        = tcm_invalid_r;
  assign tcm_invalid_addr   = tcm_invalid_addr_r;
  assign dma_rdata          = dma_rdata_r;
  assign dma_ack            = dma_ack_r;

endmodule

// File: tb/tb_tcm_ctrl.sv
// Directed bench for tcm_ctrl: one instance at WAIT=0, one at WAIT=2.
module tb_tcm_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         rd_req, wr_req, fin, inv, dreq, dwe, dack;
  logic [15:0]  addr, inv_addr, daddr;
  logic [127:0] wdata, rdata;
  logic [3:0]   dbe;
  logic [31:0]  dwdata, drdata;

  logic         b_rd_req, b_wr_req, b_fin, b_inv, b_dreq, b_dwe, b_dack;
  logic [15:0]  b_addr, b_inv_addr, b_daddr;
  logic [127:0] b_wdata, b_rdata;
  logic [3:0]   b_dbe;
  logic [31:0]  b_dwdata, b_drdata;

  int n_cmp = 0;
  int n_err = 0;
  int fin_cnt = 0;
  int inv_cnt = 0;

  localparam logic [127:0] D1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] D1_PATCHED = 128'h0F0E0D0C_0B0A0908_0706CCDD_03020100;
  localparam logic [127:0] D2 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D3 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

  tcm_ctrl #(.WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .tcm_read_request(rd_req), .tcm_write_request(wr_req), .tcm_addr(addr),
    .tcm_write_data(wdata), .tcm_read_data(rdata), .tcm_request_finish(fin),
    .tcm_invalid(inv), .tcm_invalid_addr(inv_addr),
    .dma_req(dreq), .dma_we(dwe), .dma_be(dbe), .dma_addr(daddr),
    .dma_wdata(dwdata), .dma_rdata(drdata), .dma_ack(dack)
  );

  tcm_ctrl #(.WAIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .tcm_read_request(b_rd_req), .tcm_write_request(b_wr_req), .tcm_addr(b_addr),
    .tcm_write_data(b_wdata), .tcm_read_data(b_rdata), .tcm_request_finish(b_fin),
    .tcm_invalid(b_inv), .tcm_invalid_addr(b_inv_addr),
    .dma_req(b_dreq), .dma_we(b_dwe), .dma_be(b_dbe), .dma_addr(b_daddr),
    .dma_wdata(b_dwdata), .dma_rdata(b_drdata), .dma_ack(b_dack)
  );

  always @(negedge clk) begin
    if (fin) fin_cnt++;
    if (inv) inv_cnt++;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic line_op(input logic we, input logic [15:0] a, input logic [127:0] d,
                         output int cyc);
    cyc = -1;
    addr = a;
    wdata = d;
    if (we) wr_req = 1'b1; else rd_req = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (fin) begin
        cyc = c;
        break;
      end
    end
    @(posedge clk);
    #1;
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic dma_op(input logic we, input logic [15:0] a, input logic [3:0] be,
                        input logic [31:0] d, output int cyc, output logic iv,
                        output logic [15:0] ia);
    cyc = -1;
    iv = 1'b0;
    ia = 16'h0000;
    dwe = we;
    daddr = a;
    dbe = be;
    dwdata = d;
    dreq = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (dack) begin
        cyc = c;
        iv = inv;
        ia = inv_addr;
        break;
      end
    end
    @(posedge clk);
    #1;
    dreq = 1'b0;
  endtask

  task automatic wait2_op(input logic is_dma, input logic we, input logic [15:0] a,
                          input logic [127:0] d, output int cyc);
    cyc = -1;
    b_addr = a;
    b_daddr = a;
    b_wdata = d;
    b_dwe = we;
    b_dbe = 4'hF;
    if (is_dma) b_dreq = 1'b1;
    else if (we) b_wr_req = 1'b1;
    else b_rd_req = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if ((is_dma && b_dack) || (!is_dma && b_fin)) begin
        cyc = c;
        break;
      end
    end
    @(posedge clk);
    #1;
    b_dreq = 1'b0;
    b_wr_req = 1'b0;
    b_rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({fin, inv, dack} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_pulses: got %b expected 000", {fin, inv, dack});
    end
    n_cmp++;
    if ({rdata, inv_addr, drdata} !== 176'd0) begin
      n_err++;
      $display("FAIL reset_data: got %h/%h/%h expected zeros", rdata, inv_addr, drdata);
    end
    n_cmp++;
    if ({b_fin, b_inv, b_dack, b_rdata, b_inv_addr, b_drdata} !== 179'd0) begin
      n_err++;
      $display("FAIL reset_wait2: got %h expected 0",
               {b_fin, b_inv, b_dack, b_rdata, b_inv_addr, b_drdata});
    end
    do_reset();
  endtask

  task automatic test_line_write_fill();
    int c;
    int i0;
    i0 = inv_cnt;
    line_op(1'b1, 16'h1230, D1, c);
    n_cmp++;
    if (c !== 5) begin
      n_err++;
      $display("FAIL line_wr_latency: got %0d expected 5", c);
    end
    line_op(1'b0, 16'h1238, 128'd0, c);
    n_cmp++;
    if (c !== 5) begin
      n_err++;
      $display("FAIL line_rd_latency: got %0d expected 5", c);
    end
    n_cmp++;
    if (rdata !== D1) begin
      n_err++;
      $display("FAIL line_rd_data: got %h expected %h", rdata, D1);
    end
    n_cmp++;
    if (inv_cnt !== i0) begin
      n_err++;
      $display("FAIL cache_no_invalid: got %0d pulses expected 0", inv_cnt - i0);
    end
  endtask

  task automatic test_dma();
    int c;
    logic iv;
    logic [15:0] ia;
    dma_op(1'b1, 16'h1234, 4'b0011, 32'hAABBCCDD, c, iv, ia);
    n_cmp++;
    if (c !== 2) begin
      n_err++;
      $display("FAIL dma_wr_latency: got %0d expected 2", c);
    end
    n_cmp++;
    if ({iv, ia} !== {1'b1, 16'h1230}) begin
      n_err++;
      $display("FAIL dma_wr_invalid: got %b/%h expected 1/1230", iv, ia);
    end
    line_op(1'b0, 16'h1230, 128'd0, c);
    n_cmp++;
    if (rdata !== D1_PATCHED) begin
      n_err++;
      $display("FAIL dma_be_merge: got %h expected %h", rdata, D1_PATCHED);
    end
    dma_op(1'b0, 16'h1234, 4'b0000, 32'h0, c, iv, ia);
    n_cmp++;
    if ({c, iv, drdata} !== {32'd2, 1'b0, 32'h0706CCDD}) begin
      n_err++;
      $display("FAIL dma_rd: got cyc=%0d inv=%b data=%h expected 2/0/0706ccdd", c, iv, drdata);
    end
    dma_op(1'b1, 16'h1238, 4'b0000, 32'h12345678, c, iv, ia);
    n_cmp++;
    if ({iv, ia} !== {1'b1, 16'h1230}) begin
      n_err++;
      $display("FAIL dma_be0_invalid: got %b/%h expected 1/1230", iv, ia);
    end
    line_op(1'b0, 16'h1230, 128'd0, c);
    n_cmp++;
    if ({rdata, drdata} !== {D1_PATCHED, 32'h0706CCDD}) begin
      n_err++;
      $display("FAIL dma_rdata_hold: got %h/%h expected %h/0706ccdd", rdata, drdata, D1_PATCHED);
    end
  endtask

  task automatic arb_pair(output int fc, output int ac, output logic [31:0] ar);
    fc = 0;
    ac = 0;
    ar = 32'h0;
    addr = 16'h1230;
    daddr = 16'h1230;
    dwe = 1'b0;
    rd_req = 1'b1;
    dreq = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (fin && fc == 0) fc = c;
      if (dack && ac == 0) begin
        ac = c;
        ar = drdata;
      end
      @(posedge clk);
      #1;
      if (fc != 0) rd_req = 1'b0;
      if (ac != 0) dreq = 1'b0;
      if (fc != 0 && ac != 0) break;
    end
    rd_req = 1'b0;
    dreq = 1'b0;
  endtask

  task automatic test_arbitration();
    int fc;
    int ac;
    logic [31:0] ar;
    do_reset();
    arb_pair(fc, ac, ar);
    n_cmp++;
    if ({fc, ac} !== {32'd5, 32'd8}) begin
      n_err++;
      $display("FAIL arb_first_pair: got finish=%0d ack=%0d expected 5/8", fc, ac);
    end
    n_cmp++;
    if (ar !== 32'h03020100) begin
      n_err++;
      $display("FAIL arb_dma_data: got %h expected 03020100", ar);
    end
    arb_pair(fc, ac, ar);
    n_cmp++;
    if ({fc, ac} !== {32'd8, 32'd2}) begin
      n_err++;
      $display("FAIL arb_second_pair: got finish=%0d ack=%0d expected 8/2", fc, ac);
    end
  endtask

  task automatic test_back_to_back();
    int c1;
    int c2;
    int f0;
    int i0;
    f0 = fin_cnt;
    i0 = inv_cnt;
    line_op(1'b1, 16'h1240, D2, c1);
    line_op(1'b0, 16'h1240, 128'd0, c2);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if ({c1, c2} !== {32'd5, 32'd5}) begin
      n_err++;
      $display("FAIL b2b_latency: got %0d/%0d expected 5/5", c1, c2);
    end
    n_cmp++;
    if (fin_cnt - f0 !== 2) begin
      n_err++;
      $display("FAIL b2b_finish_count: got %0d expected 2", fin_cnt - f0);
    end
    n_cmp++;
    if (rdata !== D2) begin
      n_err++;
      $display("FAIL b2b_data: got %h expected %h", rdata, D2);
    end
    n_cmp++;
    if (inv_cnt !== i0) begin
      n_err++;
      $display("FAIL b2b_no_invalid: got %0d pulses expected 0", inv_cnt - i0);
    end
  endtask

  task automatic test_wait2();
    int c;
    wait2_op(1'b0, 1'b1, 16'h1300, D2, c);
    n_cmp++;
    if (c !== 13) begin
      n_err++;
      $display("FAIL w2_line_wr_latency: got %0d expected 13", c);
    end
    wait2_op(1'b0, 1'b0, 16'h1300, 128'd0, c);
    n_cmp++;
    if ({c, b_rdata} !== {32'd13, D2}) begin
      n_err++;
      $display("FAIL w2_line_rd: got cyc=%0d data=%h expected 13/%h", c, b_rdata, D2);
    end
    wait2_op(1'b1, 1'b0, 16'h1304, 128'd0, c);
    n_cmp++;
    if ({c, b_drdata} !== {32'd4, 32'h55556666}) begin
      n_err++;
      $display("FAIL w2_dma_rd: got cyc=%0d data=%h expected 4/55556666", c, b_drdata);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    int f0;
    line_op(1'b1, 16'h1250, D3, c);
    f0 = fin_cnt;
    addr = 16'h1250;
    rd_req = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    rd_req = 1'b0;
    n_cmp++;
    if ({fin, inv, dack, rdata, inv_addr, drdata} !== 179'd0) begin
      n_err++;
      $display("FAIL midreset_outputs: got %h/%h/%h/%b expected zeros",
               rdata, inv_addr, drdata, {fin, inv, dack});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (fin_cnt !== f0) begin
      n_err++;
      $display("FAIL midreset_no_finish: got %0d pulses expected 0", fin_cnt - f0);
    end
    line_op(1'b0, 16'h1250, 128'd0, c);
    n_cmp++;
    if ({c, rdata} !== {32'd5, D3}) begin
      n_err++;
      $display("FAIL midreset_reread: got cyc=%0d data=%h expected 5/%h", c, rdata, D3);
    end
  endtask

  initial begin
    rd_req = 1'b0; wr_req = 1'b0; addr = 16'h0; wdata = 128'd0;
    dreq = 1'b0; dwe = 1'b0; dbe = 4'h0; daddr = 16'h0; dwdata = 32'h0;
    b_rd_req = 1'b0; b_wr_req = 1'b0; b_addr = 16'h0; b_wdata = 128'd0;
    b_dreq = 1'b0; b_dwe = 1'b0; b_dbe = 4'h0; b_daddr = 16'h0; b_dwdata = 32'h0;
    rst_n = 1'b1;
    #2;
    test_reset();
    test_line_write_fill();
    test_dma();
    test_arbitration();
    test_back_to_back();
    test_wait2();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
